// File: rtl/shift_pkg.sv
// shift_pkg: shared widths, operation codes and stage states for the shift/rotate datapath
package shift_pkg;
   localparam int WIDTH = 32;
   localparam int AMT_BITS = 5;
   typedef enum logic [2:0] {
      SHR  = 3'd0,
      SHRA = 3'd1,
      SHL  = 3'd2,
      ROR  = 3'd3,
      ROL  = 3'd4
   } shift_op_t;
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      HOLD = 2'd2
   } srs_state_t;
endpackage

// File: rtl/rol.sv
// rol: combinational rotate left, amount taken modulo WIDTH
module rol #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] amt,
   output logic [WIDTH-1:0] y
);
   logic [WIDTH-1:0] s;
   assign s = WIDTH'(amt % WIDTH);
   assign y = (a << s) | (a >> (WIDTH - s));
endmodule

// File: rtl/ror.sv
// ror: combinational rotate right, amount taken modulo WIDTH
module ror #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] amt,
   output logic [WIDTH-1:0] y
);
   logic [WIDTH-1:0] s;
   assign s = WIDTH'(amt % WIDTH);
   // a shift by WIDTH yields zero, so s == 0 leaves a unchanged
   assign y = (a >> s) | (a << (WIDTH - s));
endmodule

// File: rtl/shift_rotate_core.sv
// shift_rotate_core: combinational result of one shift/rotate op with amount clamping and illegal-op flag
module shift_rotate_core #(
   parameter int WIDTH = 32,
   parameter int AMT_BITS = 5
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] amt,
   input  logic [2:0]       op,
   output logic [WIDTH-1:0] z,
   output logic             err
);
   import shift_pkg::*;
   logic [AMT_BITS-1:0] sh;
   logic                big;
   logic [WIDTH-1:0]    rot_amt, ror_y, rol_y, sra_raw, shr_y, shra_y, shl_y;
   assign sh = amt[AMT_BITS-1:0];
   assign big = |amt[WIDTH-1:AMT_BITS];
   assign rot_amt = {{(WIDTH-AMT_BITS){1'b0}}, sh};
   ror #(.WIDTH(WIDTH)) u_ror (.a(a), .amt(rot_amt), .y(ror_y));
   rol #(.WIDTH(WIDTH)) u_rol (.a(a), .amt(rot_amt), .y(rol_y));
   // kept apart from the ternaries so the shift is evaluated in signed context
   assign sra_raw = $signed(a) >>> sh;
   assign shr_y = big ? '0 : a >> sh;
   assign shl_y = big ? '0 : a << sh;
   assign shra_y = big ? {WIDTH{a[WIDTH-1]}} : sra_raw;
   always_comb begin
      err = op > ROL;
      z = op == SHR  ? shr_y  :
          op == SHRA ? shra_y :
          op == SHL  ? shl_y  :
          op == ROR  ? ror_y  :
          op == ROL  ? rol_y  : '0;
   end
endmodule

// File: rtl/shift_rotate_stage.sv
// shift_rotate_stage: registered shift/rotate execution stage with valid/ready handshakes on both sides
module shift_rotate_stage #(
   parameter int WIDTH = 32,
   parameter int AMT_BITS = 5
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_z,
   output logic             out_zero,
   output logic             out_op_err,
   output logic             busy
);
   import shift_pkg::*;
   srs_state_t       state;
   logic [WIDTH-1:0] y_reg, amt_reg, res;
   logic [2:0]       op_reg;
   logic             err, accept;
   shift_rotate_core #(.WIDTH(WIDTH), .AMT_BITS(AMT_BITS)) u_core (
      .a(y_reg), .amt(amt_reg), .op(op_reg), .z(res), .err(err)
   );
   // HOLD hands over to the next request in the same cycle the result is taken
   assign in_ready = state == IDLE || (state == HOLD && out_ready);
   assign accept = in_valid && in_ready;
   assign out_valid = state == HOLD;
   assign busy = state != IDLE;
   always_ff @(posedge clock) begin
      if (clear) begin
         state <= IDLE;
         y_reg <= '0;
         amt_reg <= '0;
         op_reg <= '0;
         out_z <= '0;
         out_zero <= 1'b0;
         out_op_err <= 1'b0;
      end else begin
         if (accept) begin
            y_reg <= in_a;
            amt_reg <= in_b;
            op_reg <= in_op;
         end
         if (state == EXEC) begin
            out_z <= res;
            out_zero <= res == '0;
            out_op_err <= err;
         end
         state <= accept ? EXEC :
                  state == EXEC ? HOLD :
                  (state == HOLD && out_ready) ? IDLE : state;
      end
   end
endmodule

// File: tb/tb_shift_rotate_stage.sv
// tb_shift_rotate_stage: directed literal cases plus randomized traffic against a transaction-level model
module tb_shift_rotate_stage;
   logic        clk, clear, in_valid, in_ready, out_valid, out_ready, out_zero, out_op_err, busy;
   logic [2:0]  in_op;
   logic [31:0] in_a, in_b, out_z;
   int compared = 0;
   int mismatched = 0;

   shift_rotate_stage dut (
      .clock(clk), .clear(clear), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z),
      .out_zero(out_zero), .out_op_err(out_op_err), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ref_op(logic [2:0] op, logic [31:0] a, logic [31:0] b);
      logic [31:0] x = a;
      int n = (b >= 32) ? 32 : int'(b);
      int r = int'(b % 32);
      case (op)
         3'd0: repeat (n) x = x >> 1;
         3'd1: repeat (n) x = {x[31], x[31:1]};
         3'd2: repeat (n) x = x << 1;
         3'd3: repeat (r) x = {x[0], x[31:1]};
         3'd4: repeat (r) x = {x[30:0], x[31]};
         default: x = 32'h0;
      endcase
      return x;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // model: a request in flight for one cycle, then a result presented until taken
   bit          m_ok = 0, m_inflight = 0, m_valid = 0;
   logic [2:0]  p_op;
   logic [31:0] p_a, p_b, m_z;
   wire         m_rdy = !m_inflight && (!m_valid || out_ready);

   always @(posedge clk) begin
      if (clear) begin
         m_ok <= 1;
         m_inflight <= 0;
         m_valid <= 0;
      end else if (m_ok) begin
         if (m_inflight) begin
            m_valid <= 1;
            m_z <= ref_op(p_op, p_a, p_b);
         end else if (m_valid && out_ready) m_valid <= 0;
         m_inflight <= in_valid && m_rdy;
         if (in_valid && m_rdy) begin
            p_op <= in_op;
            p_a <= in_a;
            p_b <= in_b;
         end
      end
   end

   always @(negedge clk) begin
      if (m_ok) begin
         chk("out_valid", 32'(out_valid), 32'(m_valid));
         chk("in_ready", 32'(in_ready), 32'(m_rdy));
         chk("busy", 32'(busy), 32'(m_inflight | m_valid));
         if (m_valid) begin
            chk("out_z", out_z, m_z);
            chk("out_zero", 32'(out_zero), 32'(m_z == 0));
            chk("out_op_err", 32'(out_op_err), 32'(p_op > 3'd4));
         end
      end
   end

   task automatic run(logic [2:0] op, logic [31:0] a, logic [31:0] b,
                      logic [31:0] ez, logic ezero, logic eerr);
      in_valid = 1; in_op = op; in_a = a; in_b = b; out_ready = 1;
      tick;
      in_valid = 0; in_a = $urandom; in_b = $urandom; in_op = 3'($urandom);
      tick;
      @(negedge clk);
      chk("dir_valid", 32'(out_valid), 32'd1);
      chk("dir_z", out_z, ez);
      chk("dir_zero", 32'(out_zero), 32'(ezero));
      chk("dir_err", 32'(out_op_err), 32'(eerr));
      tick;
      @(negedge clk);
      chk("dir_ready_back", 32'(in_ready), 32'd1);
      tick;
   endtask

   initial begin
      clk = 0; clear = 1; in_valid = 0; in_op = 0; in_a = 0; in_b = 0; out_ready = 1;
      repeat (2) tick;
      clear = 0;
      @(negedge clk);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ready", 32'(in_ready), 32'd1);
      chk("rst_z", out_z, 32'd0);
      chk("rst_zero", 32'(out_zero), 32'd0);
      chk("rst_err", 32'(out_op_err), 32'd0);
      tick;
      run(3'd3, 32'h0000_0001, 32'd1,  32'h8000_0000, 0, 0);
      run(3'd4, 32'h8000_0001, 32'd36, 32'h0000_0018, 0, 0);
      run(3'd3, 32'h1234_5678, 32'd0,  32'h1234_5678, 0, 0);
      run(3'd1, 32'h8000_0000, 32'd40, 32'hFFFF_FFFF, 0, 0);
      run(3'd0, 32'h8000_0000, 32'd40, 32'h0000_0000, 1, 0);
      run(3'd2, 32'h0000_0003, 32'd31, 32'h8000_0000, 0, 0);
      run(3'd6, 32'hFFFF_FFFF, 32'd5,  32'h0000_0000, 1, 1);
      run(3'd0, 32'hF000_0000, 32'd4,  32'h0F00_0000, 0, 0);
      // backpressure with a second request waiting
      in_valid = 1; in_op = 3'd2; in_a = 32'h1; in_b = 32'd4; out_ready = 1;
      tick;
      in_op = 3'd3; in_a = 32'hF; in_b = 32'd4; out_ready = 0;
      tick;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_z", out_z, 32'h10);
         chk("bp_ready", 32'(in_ready), 32'd0);
         chk("bp_valid", 32'(out_valid), 32'd1);
         tick;
      end
      out_ready = 1;
      @(negedge clk);
      chk("bp_release_ready", 32'(in_ready), 32'd1);
      tick;
      in_valid = 0;
      tick;
      @(negedge clk);
      chk("bp_second_valid", 32'(out_valid), 32'd1);
      chk("bp_second_z", out_z, 32'hF000_0000);
      tick;
      tick;
      // clear while the request is in EXEC
      in_valid = 1; in_op = 3'd3; in_a = 32'h1; in_b = 32'd1;
      tick;
      in_valid = 0; clear = 1;
      tick;
      clear = 0;
      @(negedge clk);
      chk("clr_valid", 32'(out_valid), 32'd0);
      chk("clr_busy", 32'(busy), 32'd0);
      chk("clr_ready", 32'(in_ready), 32'd1);
      chk("clr_z", out_z, 32'd0);
      repeat (3) tick;
      for (int i = 0; i < 3000; i++) begin
         clear = $urandom_range(0, 63) == 0;
         in_valid = 1'($urandom);
         in_op = 3'($urandom_range(0, 7));
         in_a = $urandom;
         in_b = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 40));
         out_ready = $urandom_range(0, 3) != 0;
         tick;
      end
      clear = 0; in_valid = 0; out_ready = 1;
      repeat (3) tick;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
